// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Arbitrates a fetch port (read-only) and a data port (read/write) onto one
// word-addressed memory bus with a waitrequest handshake. One access is in
// flight at a time and walks IDLE -> BUS -> RESP. Ties between the two ports
// alternate, and data wins the first tie after reset.
//
// Ports
//   clock, RESET          : system clock, asynchronous active-low reset
//   f_req/f_addr          : fetch request and byte address (held until f_ack)
//   f_rdata/f_ack         : fetch read data and one-cycle completion pulse
//   d_req/d_we/d_addr     : data request, write flag, byte address
//   d_be/d_wdata          : data byte enables and write data
//   d_rdata/d_ack         : data read data and one-cycle completion pulse
//   halt                  : blocks new grants while IDLE
//   address/read/write    : bus command (registered, word aligned)
//   byteenable/writedata  : bus byte enables and write data (registered)
//   readdata/waitrequest  : bus response data and stall
//   busy                  : high whenever an access is in flight
module mem_bus_arbiter (
  input  logic        clock,
  input  logic        RESET,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic [31:0] f_rdata,
  output logic        f_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  input  logic        halt,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // The bus only ever sees whole-word addresses; the low bits are dropped
  // silently rather than flagged.
  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

  state_t      state_r, state_s;
  logic        grant_data_r, grant_data_s;  // 1 = current access belongs to data port
  logic        last_data_r, last_data_s;    // 1 = data port won the most recent grant
  logic        take_data_s;
  logic [31:0] address_r, address_s;
  logic        read_r, read_s;
  logic        write_r, write_s;
  logic [3:0]  be_r, be_s;
  logic [31:0] wdata_r, wdata_s;
  logic [31:0] f_rdata_r, f_rdata_s;
  logic [31:0] d_rdata_r, d_rdata_s;
  logic        f_ack_r, f_ack_s;
  logic        d_ack_r, d_ack_s;
  logic        busy_r, busy_s;

  // Next-state and next-output computation; every output register is loaded
  // from here so the bus and ack lines come straight off flops.
  always_comb begin
    state_s      = state_r;
    grant_data_s = grant_data_r;
    last_data_s  = last_data_r;
    take_data_s  = 1'b0;
    address_s    = address_r;
    read_s       = read_r;
    write_s      = write_r;
    be_s         = be_r;
    wdata_s      = wdata_r;
    f_rdata_s    = f_rdata_r;
    d_rdata_s    = d_rdata_r;
    f_ack_s      = 1'b0;
    d_ack_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (!halt && (f_req || d_req)) begin
          // Data wins if alone, or on a tie when fetch had the last grant.
          take_data_s  = d_req && (!f_req || !last_data_r);
          grant_data_s = take_data_s;
          last_data_s  = take_data_s;
          state_s      = BUS;
          if (take_data_s) begin
            address_s = word_align(d_addr);
            read_s    = ~d_we;
            write_s   = d_we;
            be_s      = d_be;
            wdata_s   = d_wdata;
          end else begin
            address_s = word_align(f_addr);
            read_s    = 1'b1;
            write_s   = 1'b0;
            be_s      = 4'b1111;
            wdata_s   = 32'h0000_0000;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          // Only a read updates rdata; a data write leaves d_rdata alone.
          if (!grant_data_r) begin
            f_rdata_s = readdata;
          end else if (read_r) begin
            d_rdata_s = readdata;
          end else begin
            d_rdata_s = d_rdata_r;
          end
          read_s  = 1'b0;
          write_s = 1'b0;
          f_ack_s = ~grant_data_r;
          d_ack_s = grant_data_r;
          state_s = RESP;
        end else begin
          state_s = BUS;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        read_s  = 1'b0;
        write_s = 1'b0;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset clears everything, aborting any access.
  always_ff @(posedge clock or negedge RESET) begin
    if (!RESET) begin
      state_r      <= IDLE;
      grant_data_r <= 1'b0;
      last_data_r  <= 1'b0;
      address_r    <= 32'h0000_0000;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      be_r         <= 4'b0000;
      wdata_r      <= 32'h0000_0000;
      f_rdata_r    <= 32'h0000_0000;
      d_rdata_r    <= 32'h0000_0000;
      f_ack_r      <= 1'b0;
      d_ack_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      grant_data_r <= grant_data_s;
      last_data_r  <= last_data_s;
      address_r    <= address_s;
      read_r       <= read_s;
      write_r      <= write_s;
      be_r         <= be_s;
      wdata_r      <= wdata_s;
      f_rdata_r    <= f_rdata_s;
      d_rdata_r    <= d_rdata_s;
      f_ack_r      <= f_ack_s;
      d_ack_r      <= d_ack_s;
      busy_r       <= busy_s;
    end
  end

  assign address    = address_r;
  assign read       = read_r;
  assign write      = write_r;
  assign byteenable = be_r;
  assign writedata  = wdata_r;
  assign f_rdata    = f_rdata_r;
  assign d_rdata    = d_rdata_r;
  assign f_ack      = f_ack_r;
  assign d_ack      = d_ack_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations, then randomized requesters/bus, all cross-checked every cycle
// against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        RESET;
  logic        f_req;
  logic [31:0] f_addr;
  logic [31:0] f_rdata;
  logic        f_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        halt;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        busy;

  always #5 clock = ~clock;

  mem_bus_arbiter dut (
    .clock(clock), .RESET(RESET),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .halt(halt),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .busy(busy)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 = no access, 1 = command on bus, 2 = completion cycle
  int          m_phase;
  bit          m_is_data;
  bit          m_is_write;
  bit          m_last_data;
  logic [31:0] exp_address, exp_wdata, exp_f_rdata, exp_d_rdata;
  logic [3:0]  exp_be;
  logic        exp_read, exp_write, exp_f_ack, exp_d_ack, exp_busy;

  // Round-robin pick: a lone requester always wins; a tie goes to the port
  // that did not win last time.
  function automatic bit pick_data(input bit fr, input bit dr, input bit last_d);
    if (fr && dr) return !last_d;
    return dr;
  endfunction

  always @(posedge clock or negedge RESET) begin
    if (!RESET) begin
      m_phase <= 0; m_is_data <= 1'b0; m_is_write <= 1'b0; m_last_data <= 1'b0;
      exp_address <= 32'h0; exp_wdata <= 32'h0; exp_be <= 4'h0;
      exp_f_rdata <= 32'h0; exp_d_rdata <= 32'h0;
      exp_read <= 1'b0; exp_write <= 1'b0;
      exp_f_ack <= 1'b0; exp_d_ack <= 1'b0; exp_busy <= 1'b0;
    end else if (m_phase == 2) begin
      m_phase <= 0;
      exp_f_ack <= 1'b0; exp_d_ack <= 1'b0; exp_busy <= 1'b0;
    end else if (m_phase == 1) begin
      if (!waitrequest) begin
        if (!m_is_data) exp_f_rdata <= readdata;
        else if (!m_is_write) exp_d_rdata <= readdata;
        exp_read <= 1'b0; exp_write <= 1'b0;
        exp_f_ack <= !m_is_data; exp_d_ack <= m_is_data;
        m_phase <= 2;
      end
    end else if (!halt && (f_req || d_req)) begin
      if (pick_data(f_req, d_req, m_last_data)) begin
        m_is_data <= 1'b1; m_last_data <= 1'b1; m_is_write <= d_we;
        exp_address <= d_addr & 32'hFFFF_FFFC;
        exp_read <= !d_we; exp_write <= d_we;
        exp_be <= d_be; exp_wdata <= d_wdata;
      end else begin
        m_is_data <= 1'b0; m_last_data <= 1'b0; m_is_write <= 1'b0;
        exp_address <= f_addr & 32'hFFFF_FFFC;
        exp_read <= 1'b1; exp_write <= 1'b0;
        exp_be <= 4'hF; exp_wdata <= 32'h0;
      end
      m_phase <= 1;
      exp_busy <= 1'b1;
    end
  end

  // Per-cycle comparison of the DUT against the model, away from the rising edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("m_read", read, exp_read);
      check("m_write", write, exp_write);
      check("m_rw_exclusive", read & write, 1'b0);
      check("m_f_ack", f_ack, exp_f_ack);
      check("m_d_ack", d_ack, exp_d_ack);
      check("m_busy", busy, exp_busy);
      check("m_f_rdata", f_rdata, exp_f_rdata);
      check("m_d_rdata", d_rdata, exp_d_rdata);
      if (exp_read || exp_write) begin
        check("m_address", address, exp_address);
        check("m_byteenable", byteenable, exp_be);
        check("m_writedata", writedata, exp_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  int acks_seen;
  bit order_d [4];
  bit prev_f, prev_d;

  initial begin
    RESET = 1'b0; f_req = 1'b0; f_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_be = 4'h0; d_wdata = 32'h0; halt = 1'b0;
    readdata = 32'h0; waitrequest = 1'b0;
    repeat (3) @(negedge clock);
    cmp_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_read", read, 1'b0);
    check("rst_write", write, 1'b0);
    check("rst_address", address, 32'h0);
    check("rst_byteenable", byteenable, 4'h0);
    check("rst_writedata", writedata, 32'h0);
    check("rst_acks", {f_ack, d_ack}, 2'b00);
    check("rst_rdata", f_rdata | d_rdata, 32'h0);
    #2 RESET = 1'b1;

    // Fetch read, no stall.
    @(negedge clock);
    f_req = 1'b1; f_addr = 32'hBFC0_0000; readdata = 32'h2401_000F; waitrequest = 1'b0;
    @(negedge clock);
    check("fetch_read", read, 1'b1);
    check("fetch_write", write, 1'b0);
    check("fetch_address", address, 32'hBFC0_0000);
    check("fetch_be", byteenable, 4'hF);
    check("fetch_busy", busy, 1'b1);
    @(negedge clock);
    check("fetch_read_off", read, 1'b0);
    check("fetch_ack", f_ack, 1'b1);
    check("fetch_rdata", f_rdata, 32'h2401_000F);
    check("model_fetch_rdata", exp_f_rdata, 32'h2401_000F);
    f_req = 1'b0;
    @(negedge clock);
    check("fetch_ack_pulse", f_ack, 1'b0);
    check("fetch_idle", busy, 1'b0);

    // Data write with three stall cycles on an unaligned address.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_001F; d_be = 4'b0001;
    d_wdata = 32'h0000_000F; waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("dw_write", write, 1'b1);
      check("dw_read", read, 1'b0);
      check("dw_address", address, 32'h0000_001C);
      check("dw_be", byteenable, 4'b0001);
      check("dw_wdata", writedata, 32'h0000_000F);
      check("dw_no_ack", d_ack, 1'b0);
      if (i == 3) waitrequest = 1'b0;
    end
    @(negedge clock);
    check("dw_write_off", write, 1'b0);
    check("dw_ack", d_ack, 1'b1);
    check("dw_rdata_kept", d_rdata, 32'h0);
    d_req = 1'b0;
    @(negedge clock);
    check("dw_ack_pulse", d_ack, 1'b0);

    // Contention from reset: data, fetch, data, fetch.
    @(negedge clock); #2 RESET = 1'b0;
    @(negedge clock); #2 RESET = 1'b1;
    f_req = 1'b1; f_addr = 32'h0000_0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0204; d_be = 4'hF;
    acks_seen = 0; prev_f = 1'b0; prev_d = 1'b0;
    for (int c = 0; c < 40 && acks_seen < 4; c++) begin
      @(negedge clock);
      check("tie_single_f_ack", f_ack & prev_f, 1'b0);
      check("tie_single_d_ack", d_ack & prev_d, 1'b0);
      prev_f = f_ack; prev_d = d_ack;
      if (f_ack || d_ack) begin
        order_d[acks_seen] = d_ack;
        acks_seen++;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    check("tie_ack_count", acks_seen, 4);
    check("tie_order", {order_d[0], order_d[1], order_d[2], order_d[3]}, 4'b1010);
    repeat (2) @(negedge clock);

    // Halt raised mid-access: the fetch still finishes, nothing new starts.
    f_req = 1'b1; f_addr = 32'h0000_3000; waitrequest = 1'b1;
    @(negedge clock);
    check("halt_fetch_started", read, 1'b1);
    halt = 1'b1; d_req = 1'b1; d_we = 1'b1;
    @(negedge clock);
    check("halt_fetch_held", read, 1'b1);
    waitrequest = 1'b0;
    @(negedge clock);
    check("halt_fetch_ack", f_ack, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("halt_no_strobe", read | write, 1'b0);
      check("halt_idle", busy, 1'b0);
    end
    halt = 1'b0; f_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clock);

    // Reset asserted while a read is on the bus.
    f_req = 1'b1; f_addr = 32'h0000_4008; waitrequest = 1'b1;
    @(negedge clock);
    check("rstmid_read_on", read, 1'b1);
    check("rstmid_address", address, 32'h0000_4008);
    #2 RESET = 1'b0;
    #1;
    check("rstmid_read_off", read, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_address0", address, 32'h0);
    check("rstmid_no_ack", f_ack, 1'b0);
    @(negedge clock);
    check("rstmid_still_no_ack", f_ack, 1'b0);
    #2 RESET = 1'b1; waitrequest = 1'b0;
    @(negedge clock);
    check("rstmid_restart_read", read, 1'b1);
    check("rstmid_restart_addr", address, 32'h0000_4008);
    @(negedge clock);
    check("rstmid_restart_ack", f_ack, 1'b1);
    f_req = 1'b0;
    @(negedge clock);

    // Randomized traffic with well-behaved requesters, stalls, halts, resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 299) == 0) begin
        #2 RESET = 1'b0;
        @(negedge clock);
        #2 RESET = 1'b1;
      end
      if (f_req && f_ack) f_req = 1'b0;
      else if (!f_req && $urandom_range(0, 2) == 0) begin
        f_req = 1'b1; f_addr = $urandom;
      end else if (f_req && busy && $urandom_range(0, 31) == 0) f_req = 1'b0;
      if (d_req && d_ack) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
        d_be = 4'($urandom_range(0, 15)); d_wdata = $urandom;
      end else if (d_req && busy && $urandom_range(0, 31) == 0) d_req = 1'b0;
      waitrequest = ($urandom_range(0, 2) == 0);
      halt = ($urandom_range(0, 9) == 0);
      readdata = $urandom;
    end

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
